// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Multi-cycle 32-bit divider controller for a 5-stage pipeline.
//             Performs DIV (signed) or DIVU (unsigned) using a restoring
//             shift-subtract loop, one quotient bit per cycle, MSB first.
//  Ports    : clk        - clock, rising edge active
//             rst        - asynchronous reset, active high
//             start_i    - division request, held while the instruction is in EX
//             annul_i    - cancel the operation in flight (pipeline flush)
//             signed_i   - 1 = signed (DIV), 0 = unsigned (DIVU)
//             opdata1_i  - dividend
//             opdata2_i  - divisor
//             result_o   - {remainder, quotient}, valid while ready_o = 1
//             ready_o    - result available
//             stop       - stall request to the pipeline controller
//  Revision : 1.0 - initial release
// ============================================================================
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stop
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIVZERO = 2'd1;
  localparam logic [1:0] ST_ON      = 2'd2;
  localparam logic [1:0] ST_END     = 2'd3;

  localparam logic [5:0] C_LAST_CNT = 6'd32;

  logic [1:0]  state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  // {partial remainder (33 bits), dividend/quotient (32 bits)}
  logic [64:0] work_q,    work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        qneg_q,    qneg_d;
  logic        rneg_q,    rneg_d;
  logic [63:0] result_q,  result_d;

  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // One restoring step: shift left, trial-subtract the divisor from the upper
  // half, keep the difference and emit a 1 when it does not go negative.
  always_comb begin
    w_shift = work_q << 1;
    w_diff  = w_shift[64:32] - {1'b0, divisor_q};
    w_fits  = (w_shift[64:32] >= {1'b0, divisor_q});
  end

  // Magnitudes for the unsigned core; 0x80000000 negates to itself, which is
  // the correct unsigned magnitude 2^31.
  always_comb begin
    w_abs1 = (signed_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    w_abs2 = (signed_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    w_quot = qneg_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
    w_rem  = rneg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = ST_DIVZERO;
          end else begin
            state_d   = ST_ON;
            cnt_d     = 6'd0;
            work_d    = {33'd0, w_abs1};
            divisor_d = w_abs2;
            qneg_d    = signed_i && (opdata1_i[31] ^ opdata2_i[31]);
            rneg_d    = signed_i && opdata1_i[31];
          end
        end
      end

      ST_DIVZERO: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_END;
          result_d = 64'd0;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          state_d   = ST_IDLE;
          cnt_d     = 6'd0;
          work_d    = 65'd0;
          divisor_d = 32'd0;
          qneg_d    = 1'b0;
          rneg_d    = 1'b0;
        end else if (cnt_q != C_LAST_CNT) begin
          work_d = w_fits ? {w_diff, w_shift[31:1], 1'b1} : w_shift;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = ST_END;
          cnt_d    = 6'd0;
          result_d = {w_rem, w_quot};
        end
      end

      ST_END: begin
        // Result is held while the pipeline keeps the request asserted.
        if (annul_i || !start_i) begin
          state_d  = ST_IDLE;
          result_d = 64'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == ST_END);
  // Gated by rst so a request held through reset never stalls the pipeline.
  assign stop     = start_i && (state_q != ST_END) && !annul_i && !rst;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl: directed scenarios with
//             literal expectations plus randomized traffic checked every
//             cycle against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stop;

  int n_tests = 0;
  int n_fail  = 0;

  div_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stop      (stop)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference division using language arithmetic: '/' truncates toward zero
  // and '%' takes the dividend's sign, which is exactly the required behaviour.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction model: an accepted request completes after a fixed number of
  // edges, then the answer is presented until the request is withdrawn.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res  = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= 64'd0;
    end else if (m_done) begin
      if (annul_i || !start_i) begin
        m_done <= 1'b0;
        m_res  <= 64'd0;
      end
    end else if (m_busy) begin
      if (annul_i) begin
        m_busy <= 1'b0;
        m_res  <= 64'd0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start_i && !annul_i) begin
      m_busy <= 1'b1;
      m_left <= (opdata2_i == 32'd0) ? 1 : 33;
      m_res  <= ref_div(signed_i, opdata1_i, opdata2_i);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ready",  {63'd0, ready_o}, {63'd0, m_done});
    check("result", result_o, m_done ? m_res : 64'd0);
    check("stop",   {63'd0, stop},
          {63'd0, (start_i && !m_done && !annul_i && !rst)});
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Observations start right after edge T: k = 1 is the first negedge.
  task automatic wait_ready(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    logic [63:0] held;
    @(posedge clk); #2;
    signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    @(negedge clk);
    check({nm, "_stop_at_T"}, {63'd0, stop}, 64'd1);
    @(posedge clk); #2;
    // Operands must be ignored once the division is under way.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~s;
    wait_ready(lat);
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_result"}, result_o, exp_res);
    check({nm, "_stop_drop"}, {63'd0, stop}, 64'd0);
    held = result_o;
    repeat (3) begin
      @(negedge clk);
      check({nm, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({nm, "_hold_result"}, result_o, held);
    end
    @(posedge clk); #2;
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({nm, "_release_ready"}, {63'd0, ready_o}, 64'd0);
    check({nm, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b0; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_ready",  {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_stop",   {63'd0, stop}, 64'd0);
    end
    @(posedge clk); #2;
    rst = 1'b0; start_i = 1'b0;

    run_op("udiv_100_7",    1'b0, 32'd100,       32'd7,       {32'd2, 32'd14},               34);
    run_op("sdiv_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,       {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_op("sdiv_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},       34);
    run_op("sdiv_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},       34);
    run_op("udiv_big",      1'b0, 32'hFFFF_FFFF, 32'h10,      {32'hF, 32'h0FFF_FFFF},        34);
    run_op("divzero",       1'b0, 32'd123,       32'd0,       64'd0,                         2);

    // Annul at cnt = 10, with the next request already waiting.
    @(posedge clk); #2;
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #2;
    repeat (10) @(posedge clk);
    #2;
    annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    check("annul_stop", {63'd0, stop}, 64'd0);
    @(posedge clk); #2;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_no_ready", {63'd0, ready_o}, 64'd0);
    check("annul_restart_stop", {63'd0, stop}, 64'd1);
    @(posedge clk); #2;
    wait_ready(lat);
    check("annul_then_9_3_latency", 64'(lat), 64'd34);
    check("annul_then_9_3_result", result_o, {32'd0, 32'd3});
    @(posedge clk); #2;
    start_i = 1'b0;

    // Asynchronous reset mid-ON at cnt = 20.
    @(posedge clk); #2;
    opdata1_i = 32'd1234567; opdata2_i = 32'd89; start_i = 1'b1;
    @(posedge clk); #2;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_on_ready",  {63'd0, ready_o}, 64'd0);
    check("rst_on_result", result_o, 64'd0);
    check("rst_on_stop",   {63'd0, stop}, 64'd0);
    @(posedge clk); #2;
    start_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    run_op("rst_then_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);

    // Asynchronous reset while a result is being presented.
    @(posedge clk); #2;
    opdata1_i = 32'd77; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #2;
    wait_ready(lat);
    check("end_rst_pre_result", result_o, {32'd0, 32'd11});
    #2;
    rst = 1'b1;
    #1;
    check("end_rst_ready",  {63'd0, ready_o}, 64'd0);
    check("end_rst_result", result_o, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0; start_i = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      annul_i = ($urandom_range(0, 99) < 3);
      if (m_done)      start_i = ($urandom_range(0, 99) < 60);
      else if (m_busy) start_i = ($urandom_range(0, 99) < 95);
      else             start_i = ($urandom_range(0, 99) < 50);
      if (!m_busy || $urandom_range(0, 9) == 0) begin
        opdata1_i = rnd_op();
        opdata2_i = rnd_op();
        signed_i  = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #2;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
